// File: rtl/digit_scan_driver_if.sv
// Value/handshake and display bus between a value producer and digit_scan_driver.
// The master side supplies values; the slave side converts and scans them out.
interface digit_scan_driver_if;
  logic [13:0] value;
  logic        valid;
  logic        ready;
  logic        blank_en;
  logic [3:0]  digit;
  logic [3:0]  anode;
  logic        done;
  logic        overflow;

  modport master (
    output value, valid, blank_en,
    input  ready, digit, anode, done, overflow
  );

  modport slave (
    input  value, valid, blank_en,
    output ready, digit, anode, done, overflow
  );
endinterface

// File: rtl/digit_scan_driver.sv
// Binary-to-BCD (double dabble, 16 cycles per value) feeding a 4-digit multiplexed scanner.
// Values are only accepted while idle; anodes lag the digit code by one cycle to match the decoder.
module digit_scan_driver #(
  parameter int unsigned REFRESH_DIV = 50000
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  digit_scan_driver_if.slave bus
);
  localparam int unsigned PW = $clog2(REFRESH_DIV);
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SHIFT  = 2'd1;
  localparam logic [1:0] COMMIT = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [13:0]      bin_q, bin_d;
  logic [15:0]      bcd_q, bcd_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             blank_q, blank_d;
  logic             ovf_flag_q, ovf_flag_d;
  logic [3:0][3:0]  disp_q, disp_d;
  logic             done_q, done_d;
  logic             overflow_q, overflow_d;

  logic [15:0]      bcd_adj;
  logic [3:0][3:0]  commit_dig;

  logic [PW-1:0]    presc_q;
  logic [1:0]       idx_q, idx_dly_q;
  logic             dly_vld_q;
  logic [3:0]       digit_q, anode_q;

  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < 4; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
  end

  // Leading-zero blanking never touches digit 0, so a value of 0 still shows "0".
  always_comb begin
    commit_dig = bcd_q;
    if (ovf_flag_q) begin
      commit_dig = 16'hFFFF;
    end else if (blank_q) begin
      if (bcd_q[15:12] == 4'd0) commit_dig[3] = 4'hF;
      if (bcd_q[15:8]  == 8'd0) commit_dig[2] = 4'hF;
      if (bcd_q[15:4]  == 12'd0) commit_dig[1] = 4'hF;
    end
  end

  always_comb begin
    state_d    = state_q;
    bin_d      = bin_q;
    bcd_d      = bcd_q;
    cnt_d      = cnt_q;
    blank_d    = blank_q;
    ovf_flag_d = ovf_flag_q;
    disp_d     = disp_q;
    done_d     = 1'b0;
    overflow_d = overflow_q;
    case (state_q)
      IDLE: begin
        if (bus.valid) begin
          bin_d      = bus.value;
          bcd_d      = 16'd0;
          cnt_d      = 4'd0;
          blank_d    = bus.blank_en;
          ovf_flag_d = (bus.value > 14'd9999);
          state_d    = SHIFT;
        end
      end
      SHIFT: begin
        {bcd_d, bin_d} = {bcd_adj[14:0], bin_q, 1'b0};
        cnt_d          = cnt_q + 4'd1;
        if (cnt_q == 4'd13) state_d = COMMIT;
      end
      COMMIT: begin
        disp_d     = commit_dig;
        done_d     = 1'b1;
        overflow_d = ovf_flag_q;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      bin_q      <= '0;
      bcd_q      <= '0;
      cnt_q      <= '0;
      blank_q    <= 1'b0;
      ovf_flag_q <= 1'b0;
      disp_q     <= 16'hFFFF;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      bin_q      <= bin_d;
      bcd_q      <= bcd_d;
      cnt_q      <= cnt_d;
      blank_q    <= blank_d;
      ovf_flag_q <= ovf_flag_d;
      disp_q     <= disp_d;
      done_q     <= done_d;
      overflow_q <= overflow_d;
    end
  end

  // dly_vld_q holds anodes off for the first cycle so the first enable lands two cycles after reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      presc_q   <= '0;
      idx_q     <= 2'd0;
      idx_dly_q <= 2'd0;
      dly_vld_q <= 1'b0;
      digit_q   <= 4'hF;
      anode_q   <= 4'hF;
    end else begin
      if (presc_q == PW'(REFRESH_DIV - 1)) begin
        presc_q <= '0;
        idx_q   <= idx_q + 2'd1;
      end else begin
        presc_q <= presc_q + 1'b1;
      end
      digit_q   <= disp_q[idx_q];
      idx_dly_q <= idx_q;
      dly_vld_q <= 1'b1;
      anode_q   <= dly_vld_q ? ~(4'b0001 << idx_dly_q) : 4'hF;
    end
  end

  assign bus.ready    = (state_q == IDLE);
  assign bus.digit    = digit_q;
  assign bus.anode    = anode_q;
  assign bus.done     = done_q;
  assign bus.overflow = overflow_q;
endmodule

// File: tb/tb_digit_scan_driver.sv
// Randomized and directed bench for digit_scan_driver against a decimal-arithmetic display model.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_digit_scan_driver;
  localparam int DIV = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;

  digit_scan_driver_if dif ();

  digit_scan_driver #(.REFRESH_DIV(DIV)) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (dif.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected display code for one position, straight from the decimal value.
  function automatic logic [3:0] exp_digit(input int v, input bit blk, input int pos);
    int p;
    p = 1;
    for (int i = 0; i < pos; i++) p = p * 10;
    if (v > 9999) return 4'hF;
    if (blk && pos > 0 && v < p) return 4'hF;
    return 4'((v / p) % 10);
  endfunction

  function automatic logic [15:0] exp_vec(input int v, input bit blk);
    logic [15:0] r;
    for (int i = 0; i < 4; i++) r[4*i +: 4] = exp_digit(v, blk, i);
    return r;
  endfunction

  // Pair each digit code with the anode that is active one cycle later.
  task automatic scan_check(input string tag, input logic [15:0] exp);
    logic [3:0] shown [4];
    bit         seen  [4];
    logic [3:0] prev_digit;
    logic [3:0] onehot;
    for (int j = 0; j < 4; j++) begin
      shown[j] = 4'hX;
      seen[j]  = 1'b0;
    end
    @(negedge clk);
    prev_digit = dif.digit;
    repeat (20) begin
      @(negedge clk);
      for (int j = 0; j < 4; j++) begin
        onehot = ~(4'b0001 << j);
        if (dif.anode == onehot) begin
          shown[j] = prev_digit;
          seen[j]  = 1'b1;
        end
      end
      prev_digit = dif.digit;
    end
    for (int j = 0; j < 4; j++) begin
      check($sformatf("%s_seen%0d", tag, j), seen[j], 1);
      check($sformatf("%s_digit%0d", tag, j), shown[j], exp[4*j +: 4]);
    end
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (dif.ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("ready_wait", dif.ready, 1);
  endtask

  task automatic run_conv(input int v, input bit blk);
    int n;
    int early;
    wait_ready();
    dif.value    = 14'(v);
    dif.valid    = 1'b1;
    dif.blank_en = blk;
    @(negedge clk);
    dif.valid    = 1'b0;
    dif.value    = 14'($urandom);
    dif.blank_en = ~blk;
    n = 0;
    early = 0;
    while (dif.ready !== 1'b1 && n < 40) begin
      if (dif.done) early++;
      n++;
      @(negedge clk);
    end
    check($sformatf("busy_cycles_%0d", v), n, 15);
    check($sformatf("early_done_%0d", v), early, 0);
    check($sformatf("done_pulse_%0d", v), dif.done, 1);
    check($sformatf("overflow_%0d", v), dif.overflow, (v > 9999));
    @(negedge clk);
    check($sformatf("done_width_%0d", v), dif.done, 0);
    repeat (2) @(negedge clk);
    scan_check($sformatf("conv%0d_b%0d", v, blk), exp_vec(v, blk));
  endtask

  initial begin
    logic [3:0] exp_anode;
    int         n_done;
    int         ncap;
    int         last_cap;
    int         last_v;
    int         cur;
    int         v;
    int         r;
    bit         blk;

    dif.value    = '0;
    dif.valid    = 1'b0;
    dif.blank_en = 1'b0;
    rst_n        = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ready", dif.ready, 1);
    check("rst_digit", dif.digit, 4'hF);
    check("rst_anode", dif.anode, 4'hF);
    check("rst_done", dif.done, 0);
    check("rst_overflow", dif.overflow, 0);

    // Idle scan: each index held DIV cycles, anode enable two cycles behind reset release.
    rst_n = 1'b1;
    for (int k = 1; k <= 24; k++) begin
      @(negedge clk);
      if (k < 2) exp_anode = 4'hF;
      else       exp_anode = ~(4'b0001 << (((k - 2) / DIV) % 4));
      check($sformatf("idle_anode_k%0d", k), dif.anode, exp_anode);
      check($sformatf("idle_digit_k%0d", k), dif.digit, 4'hF);
      check($sformatf("idle_ready_k%0d", k), dif.ready, 1);
    end

    run_conv(1234, 1'b0);
    run_conv(42, 1'b1);
    run_conv(0, 1'b1);
    run_conv(12000, 1'b0);

    // Reset in the middle of a conversion, with overflow still set from 12000.
    wait_ready();
    dif.value    = 14'd5678;
    dif.valid    = 1'b1;
    dif.blank_en = 1'b0;
    @(negedge clk);
    dif.valid = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_ready", dif.ready, 1);
    check("midrst_digit", dif.digit, 4'hF);
    check("midrst_anode", dif.anode, 4'hF);
    check("midrst_done", dif.done, 0);
    check("midrst_overflow", dif.overflow, 0);
    @(negedge clk);
    rst_n = 1'b1;
    n_done = 0;
    repeat (30) begin
      @(negedge clk);
      if (dif.done) n_done++;
    end
    check("midrst_no_done", n_done, 0);
    scan_check("midrst_blank", 16'hFFFF);
    run_conv(5678, 1'b0);
    run_conv(9999, 1'b0);

    // valid held high: only values presented while ready are taken, one per 16 cycles.
    wait_ready();
    ncap     = 0;
    last_cap = -1;
    last_v   = 0;
    dif.valid    = 1'b1;
    dif.blank_en = 1'b0;
    for (int cyc = 0; cyc < 64; cyc++) begin
      cur       = int'($urandom_range(0, 9999));
      dif.value = 14'(cur);
      if (dif.ready === 1'b1) begin
        if (ncap > 0) check($sformatf("cap_gap_%0d", ncap), cyc - last_cap, 16);
        last_cap = cyc;
        last_v   = cur;
        ncap++;
      end
      @(negedge clk);
    end
    dif.valid = 1'b0;
    check("cap_count", ncap, 4);
    wait_ready();
    repeat (3) @(negedge clk);
    scan_check("held_valid", exp_vec(last_v, 1'b0));

    repeat (8) begin
      r = int'($urandom_range(0, 3));
      if (r == 0)      v = int'($urandom_range(0, 9));
      else if (r == 1) v = int'($urandom_range(10, 999));
      else             v = int'($urandom_range(0, 16383));
      blk = 1'($urandom_range(0, 1));
      run_conv(v, blk);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
